sr_latch_driver: RTL and testbench
==================================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 4, setting the width in clocks of the active-low set/reset pulse (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, setting the high-high settle time in clocks after each pulse (legal range 2..255).
REQ-003 The block SHALL have port clk  input  1  the single system clock (rising edge).
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid  input  1  command request.
REQ-006 The block SHALL have port req_set  input  1  command value: 1 = set latch (Q=1), 0 = reset latch (Q=0); sampled on accept.
REQ-007 The block SHALL have port req_ready  output  1  block can accept a command.
REQ-008 The block SHALL have port S  output  1  active-low set drive to the external NAND SR latch.
REQ-009 The block SHALL have port R  output  1  active-low reset drive to the external NAND SR latch.
REQ-010 The block SHALL have port Q  input  1  latch true output, asynchronous to clk.
REQ-011 The block SHALL have port Q_not  input  1  latch complement output, asynchronous to clk.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse marking command completion.
REQ-013 The block SHALL have port err  output  1  readback mismatch, qualified by done.

Function
REQ-014 The block SHALL implement the FSM states IDLE, PULSE, GAP and FIN.
REQ-015 The block SHALL assert req_ready only in IDLE; a command is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-016 On accept the block SHALL register req_set, enter PULSE and load the counter with PULSE_CYCLES-1.
REQ-017 In PULSE the block SHALL drive S=0 when req_set=1 and R=0 when req_set=0, for exactly PULSE_CYCLES clocks after the accept edge.
REQ-018 The block SHALL never drive S=0 and R=0 in the same cycle, including on any transition; this is the invalid latch input.
REQ-019 The block SHALL enter GAP from PULSE when the counter reaches 0, drive S=1 and R=1, and hold GAP for GAP_CYCLES clocks.
REQ-020 The block SHALL enter FIN after GAP and, in FIN, assert done=1 for one cycle, then return to IDLE.
REQ-021 Latency SHALL be fixed: done is high in the cycle after edge PULSE_CYCLES+GAP_CYCLES+1, counting the accept edge as edge 0.
REQ-022 In PULSE, GAP and FIN the block SHALL ignore req_valid without side effects and SHALL NOT queue commands.
REQ-023 The block SHALL pass Q and Q_not through a two-flop synchroniser before any use.
REQ-024 S and R SHALL be driven directly from flops, with no combinational decode on the outputs.
REQ-025 The counter SHALL be 8 bits wide and SHALL never wrap; it only decrements to 0.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately, without a clock, force S=1, R=1, req_ready=1, done=0, err=0, state IDLE, counter 0, and synchroniser flops 0.
REQ-027 A reset asserted mid-PULSE SHALL release the latch drive at once, leaving the latch holding its state; the command SHALL be dropped with no done.
REQ-028 After rst_n deasserts, the block SHALL be able to accept a command on the first rising edge.

Configuration
REQ-029 With macro SR_LATCH_DRIVER_READBACK_EN defined, the block SHALL compare, in FIN, synchronised Q==req_set and Q_not==~req_set, and drive err=1 together with done on mismatch.
REQ-030 Without SR_LATCH_DRIVER_READBACK_EN, err SHALL be tied to 0, the synchronisers SHALL be omitted, and Q and Q_not SHALL be unused.

Structure
REQ-031 A shared package sr_latch_pkg SHALL hold the FSM state enum (IDLE, PULSE, GAP, FIN), the counter width constant (8) and the parameter defaults.
REQ-032 The synchroniser SHALL be a separate sub-module sync2 (1-bit, two flops, async active-low reset), instantiated once for Q and once for Q_not.

Verification
REQ-033 Reset, then accept req_set=1 with defaults -> S=0 for 4 cycles, R=1 throughout, done high 7 cycles after the accept edge, and with a model latch Q=1, err=0.
REQ-034 Accept req_set=0 -> R=0 for 4 cycles, S=1 throughout, and the model latch Q=0, Q_not=1 at done.
REQ-035 Hold req_valid=1 continuously for 3 commands -> the bench observes commands back-to-back every 8 cycles, with S and R never both 0, checked by assertion every cycle.
REQ-036 Pulse rst_n low 2 cycles into PULSE -> S=R=1 within the same cycle, no done, the latch model keeps its value, and the next command completes normally.
REQ-037 With READBACK_EN, a stuck-at-0 latch model and req_set=1 -> done=1 and err=1 in the same cycle; without READBACK_EN -> err=0.
REQ-038 Set PULSE_CYCLES=1 and GAP_CYCLES=2 -> a single-cycle low pulse and done 4 cycles after the accept edge.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the SR latch driver: FSM state encoding,
// counter width and default pulse/gap timing.
package sr_latch_pkg;

  localparam int CNT_W            = 8;
  localparam int PULSE_CYCLES_DEF = 4;
  localparam int GAP_CYCLES_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit, async active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external NAND SR latch with a timed active-low set/reset pulse,
// then a settle gap. Optional readback check enabled by SR_LATCH_DRIVER_READBACK_EN.
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Q_not,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_q, set_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_d;
  logic             mismatch;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic q_sync;
  logic qn_sync;
  logic err_q;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Q),
    .q     (q_sync)
  );

  sync2 u_sync_qn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Q_not),
    .q     (qn_sync)
  );

  assign mismatch = (q_sync != set_q) || (qn_sync != ~set_q);
`else
  logic unused_latch_in;

  assign unused_latch_in = Q ^ Q_not;
  assign mismatch        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          set_d   = req_set;
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        err_d   = mismatch;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Drive is decoded from the next state so S/R come straight off flops
    // and only one of them can ever be low.
    s_d = !((state_d == PULSE) && set_d);
    r_d = !((state_d == PULSE) && !set_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      s_q     <= 1'b1;
      r_q     <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

`ifdef SR_LATCH_DRIVER_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err;

  assign unused_err = err_d;
  assign err        = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with NAND SR latch models; expected err
// depends on whether SR_LATCH_DRIVER_READBACK_EN is defined.
module tb_sr_latch_driver;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_set, req_ready, S, R, Q, Q_not, done, err;
  logic valid2, set2, ready2, S2, R2, Q2, Qn2, done2, err2;
  logic stuck = 1'b0;
  logic lq    = 1'b0;
  logic lq2   = 1'b0;

  always #5 clk = ~clk;

  always @(S or R) begin
    if (!S) lq = 1'b1;
    else if (!R) lq = 1'b0;
  end

  always @(S2 or R2) begin
    if (!S2) lq2 = 1'b1;
    else if (!R2) lq2 = 1'b0;
  end

  assign Q     = stuck ? 1'b0 : lq;
  assign Q_not = stuck ? 1'b1 : ~lq;
  assign Q2    = lq2;
  assign Qn2   = ~lq2;

  sr_latch_driver dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
    .req_ready(req_ready), .S(S), .R(R), .Q(Q), .Q_not(Q_not),
    .done(done), .err(err)
  );

  sr_latch_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_set(set2),
    .req_ready(ready2), .S(S2), .R(R2), .Q(Q2), .Q_not(Qn2),
    .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one command and check it up to the done cycle (edge 7 after accept).
  task automatic cmd(input logic v, input bit hold);
    logic exp_q;
    req_valid = 1'b1;
    req_set   = v;
    tick();
    if (!hold) req_valid = 1'b0;
    for (int e = 0; e < 8; e++) begin
      chk("S_drive", S, (v && e < 4) ? 1'b0 : 1'b1);
      chk("R_drive", R, (!v && e < 4) ? 1'b0 : 1'b1);
      chk("ready", req_ready, e == 7);
      chk("done", done, e == 7);
      if (e == 7) begin
        exp_q = stuck ? 1'b0 : v;
        chk("latch_q", Q, exp_q);
        chk("latch_qn", Q_not, ~exp_q);
        chk("err", err, RB && stuck);
      end
      if (e < 7) tick();
    end
  endtask

  always @(negedge clk) begin
    n_assert++;
    assert (!(S === 1'b0 && R === 1'b0)) else begin
      n_fail++;
      $error("FAIL sr_both_low observed=S%bR%b expected=not_both_0", S, R);
    end
    n_assert++;
    assert (!(S2 === 1'b0 && R2 === 1'b0)) else begin
      n_fail++;
      $error("FAIL sr2_both_low observed=S%bR%b expected=not_both_0", S2, R2);
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_set   = 1'b0;
    valid2    = 1'b0;
    set2      = 1'b0;
    #12;
    chk("rst_S", S, 1'b1);
    chk("rst_R", R, 1'b1);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    cmd(1'b1, 1'b0);
    tick();
    cmd(1'b0, 1'b0);
    tick();
    tick();

    // Valid held high: three commands accepted back to back, nothing queued.
    cmd(1'b1, 1'b1);
    cmd(1'b0, 1'b1);
    cmd(1'b1, 1'b1);
    req_valid = 1'b0;
    tick();
    chk("b2b_no_extra_ready", req_ready, 1'b1);
    chk("b2b_no_extra_S", S, 1'b1);
    chk("b2b_done_drop", done, 1'b0);

    // Reset two cycles into a reset pulse.
    req_valid = 1'b1;
    req_set   = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_R_low", R, 1'b0);
    chk("mid_q_cleared", Q, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_S", S, 1'b1);
    chk("mid_rst_R", R, 1'b1);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_q_held", Q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dropped_no_done", done, 1'b0);
      chk("dropped_q_held", Q, 1'b0);
    end
    cmd(1'b1, 1'b0);
    tick();

    stuck = 1'b1;
    cmd(1'b1, 1'b0);
    tick();
    stuck = 1'b0;
    tick();

    // Minimum pulse configuration: one-cycle pulse, done after edge 4.
    valid2 = 1'b1;
    set2   = 1'b1;
    tick();
    valid2 = 1'b0;
    for (int e = 0; e < 6; e++) begin
      chk("p1_S", S2, (e == 0) ? 1'b0 : 1'b1);
      chk("p1_R", R2, 1'b1);
      chk("p1_done", done2, e == 4);
      if (e == 4) begin
        chk("p1_err", err2, 1'b0);
        chk("p1_latch_q", Q2, 1'b1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
